tcp_tx_serializer: RTL and testbench

//   Feeds the SiTCP TCP TX byte interface (tcp_tx_wr / tcp_txd / tcp_tx_full) from a 32-bit
//   AXI4-Stream source. Buffers whole words in a FIFO, then serializes them to bytes at 1 byte/clk.

---
 rtl/tcp_tx_serializer_if.sv | 15 +
 rtl/tcp_tx_serializer.sv | 159 +++++++++++++++
 tb/tb_tcp_tx_serializer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/tcp_tx_serializer_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tcp_tx_serializer_if : 32-bit AXI4-Stream word channel with byte keep  |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
interface tcp_tx_serializer_if;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tvalid;
  logic        tready;

  modport master (output tdata, output tkeep, output tvalid, input tready);
  modport slave  (input tdata, input tkeep, input tvalid, output tready);
endinterface
`default_nettype wire

// File: rtl/tcp_tx_serializer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tcp_tx_serializer : AXI4-Stream words -> SiTCP TX bytes, 1 byte/clk    |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module tcp_tx_serializer #(
  parameter int FIFO_DEPTH     = 16,
  parameter int BIG_ENDIAN     = 1,
  parameter int FLUSH_ON_CLOSE = 1
) (
  input  wire logic                          m_axi_aclk,
  input  wire logic                          m_axi_aresetn,
  tcp_tx_serializer_if.slave                 s_axis,
  input  wire logic                          tcp_open_ack,
  input  wire logic                          tcp_tx_full,
  output logic                               tcp_tx_wr,
  output logic [7:0]                         tcp_txd,
  output logic [$clog2(FIFO_DEPTH):0]        fifo_count,
  output logic [15:0]                        drop_count
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  logic [35:0]   mem [FIFO_DEPTH];
  logic [35:0]   head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          flush;
  logic          push;
  logic          pop;
  logic          drop;

  state_t        state;
  state_t        state_nxt;
  logic [31:0]   sh_data;
  logic [31:0]   sh_data_nxt;
  logic [3:0]    rem_mask;
  logic [3:0]    rem_mask_nxt;
  logic [3:0]    mask_cleared;
  logic [1:0]    sel;
  logic          wr_nxt;
  logic [7:0]    txd_nxt;

  // count never exceeds FIFO_DEPTH (a power of two), so its MSB alone marks full
  assign fifo_full  = count[AW];
  assign fifo_empty = (count == '0);
  assign flush      = (FLUSH_ON_CLOSE != 0) && !tcp_open_ack;
  assign head       = mem[rd_ptr];

  assign s_axis.tready = m_axi_aresetn && (flush || !fifo_full);
  assign push          = s_axis.tvalid && s_axis.tready && !flush;
  assign drop          = s_axis.tvalid && s_axis.tready && flush;
  assign fifo_count    = count;

  // Walk lanes from lowest to highest priority so the last hit wins
  always_comb begin
    sel = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (BIG_ENDIAN != 0) begin
        if (rem_mask[3 - i]) sel = 2'(3 - i);
      end else begin
        if (rem_mask[i]) sel = 2'(i);
      end
    end
  end

  assign mask_cleared = rem_mask & ~(4'b0001 << sel);

  always_comb begin
    state_nxt    = state;
    sh_data_nxt  = sh_data;
    rem_mask_nxt = rem_mask;
    wr_nxt       = 1'b0;
    txd_nxt      = tcp_txd;
    pop          = 1'b0;
    if (flush) begin
      state_nxt    = IDLE;
      sh_data_nxt  = '0;
      rem_mask_nxt = '0;
    end else if (tcp_open_ack) begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            pop          = 1'b1;
            sh_data_nxt  = head[31:0];
            rem_mask_nxt = head[35:32];
            state_nxt    = SHIFT;
          end
        end
        SHIFT: begin
          if (!tcp_tx_full) begin
            if (rem_mask != '0) begin
              wr_nxt  = 1'b1;
              txd_nxt = sh_data[{sel, 3'b000} +: 8];
            end
            rem_mask_nxt = mask_cleared;
            // Last lane of this word (or an all-zero keep): chain straight into the next one
            if (mask_cleared == '0) begin
              if (!fifo_empty) begin
                pop          = 1'b1;
                sh_data_nxt  = head[31:0];
                rem_mask_nxt = head[35:32];
              end else begin
                state_nxt = IDLE;
              end
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge m_axi_aclk) begin
    if (!m_axi_aresetn) begin
      state      <= IDLE;
      sh_data    <= '0;
      rem_mask   <= '0;
      tcp_tx_wr  <= 1'b0;
      tcp_txd    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      drop_count <= '0;
    end else begin
      state     <= state_nxt;
      sh_data   <= sh_data_nxt;
      rem_mask  <= rem_mask_nxt;
      tcp_tx_wr <= wr_nxt;
      tcp_txd   <= txd_nxt;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
      if (drop && (drop_count != 16'hFFFF)) drop_count <= drop_count + 1'b1;
    end
  end

  always_ff @(posedge m_axi_aclk) begin
    if (push) mem[wr_ptr] <= {s_axis.tkeep, s_axis.tdata};
  end
endmodule
`default_nettype wire

// File: tb/tb_tcp_tx_serializer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_tcp_tx_serializer : directed self-checking bench                    |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module tb_tcp_tx_serializer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        open_ack;
  logic        tx_full;
  logic        tcp_tx_wr;
  logic [7:0]  tcp_txd;
  logic [4:0]  fifo_count;
  logic [15:0] drop_count;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [7:0] byte_q[$];
  int         cyc_q[$];

  tcp_tx_serializer_if axis_if ();

  tcp_tx_serializer #(
    .FIFO_DEPTH     (16),
    .BIG_ENDIAN     (1),
    .FLUSH_ON_CLOSE (1)
  ) dut (
    .m_axi_aclk    (clk),
    .m_axi_aresetn (rst_n),
    .s_axis        (axis_if.slave),
    .tcp_open_ack  (open_ack),
    .tcp_tx_full   (tx_full),
    .tcp_tx_wr     (tcp_tx_wr),
    .tcp_txd       (tcp_txd),
    .fifo_count    (fifo_count),
    .drop_count    (drop_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (tcp_tx_wr) begin
      byte_q.push_back(tcp_txd);
      cyc_q.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the handshake edge
  task automatic send(input logic [31:0] d, input logic [3:0] k, input int bound,
                      output logic ok, output int hs);
    int n;
    n = 0;
    axis_if.tdata  = d;
    axis_if.tkeep  = k;
    axis_if.tvalid = 1'b1;
    while (!axis_if.tready && n < bound) begin
      @(negedge clk);
      n++;
    end
    ok = axis_if.tready;
    if (ok) @(negedge clk);
    hs = cyc;
    axis_if.tvalid = 1'b0;
  endtask

  task automatic send_chk(input string tag, input logic [31:0] d, input logic [3:0] k, output int hs);
    logic ok;
    send(d, k, 50, ok, hs);
    check(tag, 32'(ok), 32'd1);
  endtask

  task automatic wait_bytes(input string tag, input int n);
    int t;
    t = 0;
    while (byte_q.size() < n && t < 100) begin
      @(negedge clk);
      t++;
    end
    check(tag, 32'(byte_q.size() >= n), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs;
    int gaps;
    int accepted;
    logic ok;
    logic [7:0] exp2 [12] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3,
                              8'hC0, 8'hC1, 8'hC2, 8'hC3};

    rst_n = 1'b0; open_ack = 1'b0; tx_full = 1'b0;
    axis_if.tdata = '0; axis_if.tkeep = '0; axis_if.tvalid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wr", 32'(tcp_tx_wr), 32'd0);
    check("rst_txd", 32'(tcp_txd), 32'd0);
    check("rst_tready", 32'(axis_if.tready), 32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_drop_count", 32'(drop_count), 32'd0);
    rst_n = 1'b1; open_ack = 1'b1;
    @(negedge clk);

    // Single word: first byte two edges after the handshake, big-endian order
    byte_q.delete(); cyc_q.delete();
    send_chk("t1_hs", 32'h11223344, 4'hF, hs);
    repeat (8) @(negedge clk);
    check("t1_count", byte_q.size(), 4);
    if (byte_q.size() == 4) begin
      check("t1_b0", byte_q[0], 8'h11);
      check("t1_b1", byte_q[1], 8'h22);
      check("t1_b2", byte_q[2], 8'h33);
      check("t1_b3", byte_q[3], 8'h44);
      check("t1_first_lat", cyc_q[0] - hs, 2);
      check("t1_last_lat", cyc_q[3] - hs, 5);
    end

    // Three back-to-back words, no gaps
    byte_q.delete(); cyc_q.delete();
    send_chk("t2_hs0", 32'hA0A1A2A3, 4'hF, hs);
    send_chk("t2_hs1", 32'hB0B1B2B3, 4'hF, hs);
    send_chk("t2_hs2", 32'hC0C1C2C3, 4'hF, hs);
    repeat (20) @(negedge clk);
    check("t2_count", byte_q.size(), 12);
    gaps = 0;
    for (int i = 0; i < byte_q.size() && i < 12; i++) begin
      check($sformatf("t2_b%0d", i), byte_q[i], exp2[i]);
      if (i > 0 && cyc_q[i] != cyc_q[i-1] + 1) gaps++;
    end
    check("t2_gaps", gaps, 0);

    // Backpressure for 5 decision cycles after the 2nd byte
    byte_q.delete(); cyc_q.delete();
    send_chk("t3_hs", 32'h55667788, 4'hF, hs);
    wait_bytes("t3_wait2", 2);
    tx_full = 1'b1;
    repeat (5) @(negedge clk);
    tx_full = 1'b0;
    repeat (10) @(negedge clk);
    check("t3_count", byte_q.size(), 4);
    if (byte_q.size() == 4) begin
      check("t3_b0", byte_q[0], 8'h55);
      check("t3_b1", byte_q[1], 8'h66);
      check("t3_b2", byte_q[2], 8'h77);
      check("t3_b3", byte_q[3], 8'h88);
      check("t3_gap", cyc_q[2] - cyc_q[1], 6);
    end

    // Sparse keep, then an all-zero keep word
    byte_q.delete(); cyc_q.delete();
    send_chk("t4_hs0", 32'hAABBCCDD, 4'b1010, hs);
    send_chk("t4_hs1", 32'h12345678, 4'b0000, hs);
    repeat (10) @(negedge clk);
    check("t4_count", byte_q.size(), 2);
    if (byte_q.size() == 2) begin
      check("t4_b0", byte_q[0], 8'hAA);
      check("t4_b1", byte_q[1], 8'hCC);
    end
    check("t4_fifo_empty", 32'(fifo_count), 32'd0);

    // Fill under tx_full: 1 word in the shift register plus 16 in the FIFO
    byte_q.delete(); cyc_q.delete();
    tx_full = 1'b1;
    accepted = 0;
    for (int i = 0; i < 20; i++) begin
      send(32'h10203040 + 32'(i), 4'hF, 5, ok, hs);
      if (ok) accepted++;
    end
    check("t5_accepted", accepted, 17);
    check("t5_tready", 32'(axis_if.tready), 32'd0);
    check("t5_fifo_count", 32'(fifo_count), 32'd16);
    check("t5_no_bytes", byte_q.size(), 0);
    tx_full = 1'b0;
    repeat (100) @(negedge clk);
    check("t5_drain_count", byte_q.size(), 68);
    if (byte_q.size() == 68) begin
      check("t5_first", byte_q[0], 8'h10);
      check("t5_last", byte_q[67], 8'h50);
    end

    // Close mid-word: flush, then inputs are dropped and counted
    byte_q.delete(); cyc_q.delete();
    send_chk("t6_hs0", 32'hDEADBEEF, 4'hF, hs);
    send_chk("t6_hs1", 32'hCAFEF00D, 4'hF, hs);
    wait_bytes("t6_wait2", 2);
    open_ack = 1'b0;
    @(negedge clk);
    check("t6_wr_off", 32'(tcp_tx_wr), 32'd0);
    check("t6_fifo_flushed", 32'(fifo_count), 32'd0);
    check("t6_tready_closed", 32'(axis_if.tready), 32'd1);
    for (int i = 0; i < 3; i++) send_chk("t6_drop_hs", 32'h0BAD0000 + 32'(i), 4'hF, hs);
    @(negedge clk);
    check("t6_drop_count", 32'(drop_count), 32'd3);
    open_ack = 1'b1;
    repeat (6) @(negedge clk);
    check("t6_no_residue", byte_q.size(), 2);
    check("t6_fifo_after", 32'(fifo_count), 32'd0);

    // Reset mid-stream
    byte_q.delete(); cyc_q.delete();
    send_chk("t7_hs0", 32'h01020304, 4'hF, hs);
    send_chk("t7_hs1", 32'h05060708, 4'hF, hs);
    wait_bytes("t7_wait1", 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("t7_wr", 32'(tcp_tx_wr), 32'd0);
    check("t7_txd", 32'(tcp_txd), 32'd0);
    check("t7_tready", 32'(axis_if.tready), 32'd0);
    check("t7_fifo_count", 32'(fifo_count), 32'd0);
    check("t7_drop_count", 32'(drop_count), 32'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("t7_no_residue", byte_q.size(), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
